imem_responder: RTL

Instruction-fetch responder for the RISC core: the memory-side end of the CPU's program-counter fetch path. Accepts one fetch request at a time carrying a 32-bit byte address (the CPU's `pc`), and returns the addressed 32-bit instruction word after a fixed, parameterised latency over a valid/ready handshake. Includes a bench-side load port so test benches preload programs before releasing the core.

---
 rtl/risc_pkg.sv | 14 +
 rtl/imem_array.sv | 33 +++
 rtl/imem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core memory-side blocks: word width,
// the NOP encoding returned on faulted fetches, and the fetch FSM states.
package risc_pkg;

  localparam int RISC_WORD_W = 32;
  localparam logic [RISC_WORD_W-1:0] RISC_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous read port, one synchronous
// write port, read-before-write on a same-address collision.
module imem_array
  import risc_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [RISC_WORD_W-1:0]     rd_data,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [RISC_WORD_W-1:0]     wr_data
);

  logic [RISC_WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage itself has no reset so it stays mappable to block RAM;
  // only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking assignments on both ports make a same-edge read see
  // the pre-write contents, which is what gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding fetch, fixed LATENCY, valid/ready
// on both sides. Define IMEM_ERR_EN to enable misaligned/out-of-range faults.
module imem_responder
  import risc_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_pc,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RISC_WORD_W-1:0]    rsp_data,
  output logic                      rsp_err,
  input  logic                      ld_en,
  input  logic [$clog2(DEPTH)-1:0]  ld_addr,
  input  logic [RISC_WORD_W-1:0]    ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  fetch_state_e           state;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic [RISC_WORD_W-1:0] rd_data;

  // Combinational from rsp_ready so a new request can fall through while the
  // current response is being consumed.
  assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
  assign accept    = req_valid && req_ready;

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (accept),
    .rd_addr (req_pc[AW+1:2]),
    .rd_data (rd_data),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      state     <= (LATENCY == 1) ? RESP : WAIT;
      rsp_valid <= (LATENCY == 1);
    end else begin
      case (state)
        WAIT: begin
          // Leaving on the last count keeps acceptance-to-valid at LATENCY.
          if (cnt <= CW'(1)) begin
            cnt       <= '0;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_ERR_EN
  logic fault;
  logic err_q;

  assign fault = (req_pc[1:0] != 2'b00) || (req_pc[31:AW+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= fault;
  end

  assign rsp_err  = err_q;
  assign rsp_data = err_q ? RISC_NOP : rd_data;
`else
  // Without fault checking the low and high address bits simply do not matter.
  logic unused_pc;
  assign unused_pc = ^{req_pc[31:AW+2], req_pc[1:0]};

  assign rsp_err  = 1'b0;
  assign rsp_data = rd_data;
`endif

endmodule
